// File: rtl/sram_like_port_bridge_if.sv
// Purpose: sram-like request/response bus between a port bridge and the AXI converter.
// Latency: n/a (signal bundle only).
// Backpressure: request held by master until addr_ok; responses flagged by data_ok.
//
// Signals: req/wr/size/addr/wdata (master -> slave), addr_ok/data_ok/rdata (slave -> master).
interface sram_like_port_bridge_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [31:0]       rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_port_bridge.sv
// Purpose: converts the core's single-cycle SRAM-style port into sram-like req/resp transactions.
// Latency: request issued the cycle after sram_en; result visible the cycle after data_ok.
// Backpressure: stall held high until the response lands (or is drained after a flush).
//
// Ports: clk/rst; core side sram_en/sram_wen/sram_addr/sram_wdata in, sram_rdata/stall out;
// longest_stall/flush pipeline controls; bus = sram-like master; stall_cycles = stalled-cycle count.
module sram_like_port_bridge #(
  parameter int ADDR_W     = 32,
  parameter bit WRITE_EN   = 1'b1,
  parameter bit ALIGN_READ = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sram_en,
  input  logic [3:0]             sram_wen,
  input  logic [ADDR_W-1:0]      sram_addr,
  input  logic [31:0]            sram_wdata,
  output logic [31:0]            sram_rdata,
  output logic                   stall,
  input  logic                   longest_stall,
  input  logic                   flush,
  sram_like_port_bridge_if.master bus,
  output logic [CNT_W-1:0]       stall_cycles
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

  state_t      state;
  logic        cancel;    // flush seen while the request was still waiting for addr_ok
  logic [31:0] rbuf;
  logic        is_write;
  logic [1:0]  enc_size;
  logic [1:0]  enc_off;

  // Derive transfer size and low address bits from the byte enables.
  always_comb begin
    is_write = WRITE_EN && (sram_wen != 4'b0000);
    enc_size = 2'd2;
    enc_off  = ALIGN_READ ? 2'b00 : sram_addr[1:0];
    if (is_write) begin
      enc_off = 2'b00;
      case (sram_wen)
        4'b0001: begin enc_size = 2'd0; enc_off = 2'd0; end
        4'b0010: begin enc_size = 2'd0; enc_off = 2'd1; end
        4'b0100: begin enc_size = 2'd0; enc_off = 2'd2; end
        4'b1000: begin enc_size = 2'd0; enc_off = 2'd3; end
        4'b0011: begin enc_size = 2'd1; enc_off = 2'd0; end
        4'b1100: begin enc_size = 2'd1; enc_off = 2'd2; end
        default: begin enc_size = 2'd2; enc_off = 2'd0; end
      endcase
    end
  end

  // DONE is the only state in which the core may consume the result.
  assign stall      = sram_en && (state != DONE);
  assign sram_rdata = rbuf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cancel       <= 1'b0;
      bus.req      <= 1'b0;
      bus.wr       <= 1'b0;
      bus.size     <= 2'd0;
      bus.addr     <= '0;
      bus.wdata    <= '0;
      rbuf         <= '0;
      stall_cycles <= '0;
    end else begin
      if (stall) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (sram_en && !flush) begin
            bus.req   <= 1'b1;
            bus.wr    <= is_write;
            bus.size  <= enc_size;
            bus.addr  <= {sram_addr[ADDR_W-1:2], enc_off};
            bus.wdata <= sram_wdata;
            cancel    <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          // The request cannot be withdrawn; a flush only marks it for draining.
          if (flush) begin
            cancel <= 1'b1;
          end
          if (bus.addr_ok) begin
            bus.req <= 1'b0;
            state   <= (cancel || flush) ? DRAIN : WAIT;
          end
        end
        WAIT: begin
          if (bus.data_ok) begin
            if (!flush && !bus.wr) begin
              rbuf <= bus.rdata;
            end
            state <= flush ? IDLE : DONE;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DONE: begin
          // Hold the result while the whole pipeline is frozen.
          if (flush || !longest_stall) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (bus.data_ok) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_port_bridge.sv
module tb_sram_like_port_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sram_en = 1'b0;
  logic [3:0]  sram_wen = 4'd0;
  logic [31:0] sram_addr = 32'd0;
  logic [31:0] sram_wdata = 32'd0;
  logic        longest_stall = 1'b0;
  logic        flush = 1'b0;
  logic        addr_ok = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] rdata = 32'd0;

  logic [31:0] rd_d, rd_i;
  logic        stall_d, stall_i;
  logic [31:0] cnt_d, cnt_i;

  sram_like_port_bridge_if #(.ADDR_W(32)) bus_d ();
  sram_like_port_bridge_if #(.ADDR_W(32)) bus_i ();

  assign bus_d.addr_ok = addr_ok;
  assign bus_d.data_ok = data_ok;
  assign bus_d.rdata   = rdata;
  assign bus_i.addr_ok = addr_ok;
  assign bus_i.data_ok = data_ok;
  assign bus_i.rdata   = rdata;

  // Data channel: writes allowed, aligned reads.
  sram_like_port_bridge #(.ADDR_W(32), .WRITE_EN(1'b1), .ALIGN_READ(1'b1), .CNT_W(32)) u_dch (
    .clk(clk), .rst(rst), .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(rd_d), .stall(stall_d), .longest_stall(longest_stall),
    .flush(flush), .bus(bus_d), .stall_cycles(cnt_d)
  );

  // Instruction channel: read-only, unaligned read addresses passed through.
  sram_like_port_bridge #(.ADDR_W(32), .WRITE_EN(1'b0), .ALIGN_READ(1'b0), .CNT_W(32)) u_ich (
    .clk(clk), .rst(rst), .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(rd_i), .stall(stall_i), .longest_stall(longest_stall),
    .flush(flush), .bus(bus_i), .stall_cycles(cnt_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: expected request fields, result buffers, stall count.
  logic        e_d_wr;
  logic [1:0]  e_d_size;
  logic [31:0] e_d_addr;
  logic [31:0] e_i_addr;
  logic [31:0] e_wd;
  logic [31:0] dbuf = 32'd0;
  logic [31:0] ibuf = 32'd0;
  logic [31:0] cnt_exp = 32'd0;

  logic [3:0] wen_tab [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010,
                               4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // Expected bus fields for an access, straight from the byte-enable table.
  task automatic set_exp(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd);
    logic [1:0] sz;
    logic [1:0] off;
    e_wd     = wd;
    e_i_addr = a;
    if (wen == 4'b0000) begin
      e_d_wr = 1'b0; sz = 2'd2; off = 2'd0;
    end else begin
      e_d_wr = 1'b1;
      case (wen)
        4'b0001: begin sz = 2'd0; off = 2'd0; end
        4'b0010: begin sz = 2'd0; off = 2'd1; end
        4'b0100: begin sz = 2'd0; off = 2'd2; end
        4'b1000: begin sz = 2'd0; off = 2'd3; end
        4'b0011: begin sz = 2'd1; off = 2'd0; end
        4'b1100: begin sz = 2'd1; off = 2'd2; end
        default: begin sz = 2'd2; off = 2'd0; end
      endcase
    end
    e_d_size = sz;
    e_d_addr = {a[31:2], off};
  endtask

  // One clock cycle: inputs already driven; sample mid-cycle, then advance.
  task automatic cycle_chk(input logic exp_stall, input logic exp_req, input logic rdv);
    @(negedge clk);
    chk("d_stall", stall_d, exp_stall);
    chk("i_stall", stall_i, exp_stall);
    chk("d_cnt", cnt_d, cnt_exp);
    chk("i_cnt", cnt_i, cnt_exp);
    chk("d_req", bus_d.req, exp_req);
    chk("i_req", bus_i.req, exp_req);
    if (exp_req) begin
      chk("d_wr", bus_d.wr, e_d_wr);
      chk("d_size", bus_d.size, e_d_size);
      chk("d_addr", bus_d.addr, e_d_addr);
      chk("d_wdata", bus_d.wdata, e_wd);
      chk("i_wr", bus_i.wr, 32'd0);
      chk("i_size", bus_i.size, 32'd2);
      chk("i_addr", bus_i.addr, e_i_addr);
      chk("i_wdata", bus_i.wdata, e_wd);
    end
    if (rdv) begin
      chk("d_rdata", rd_d, dbuf);
      chk("i_rdata", rd_i, ibuf);
    end
    if (exp_stall) cnt_exp = cnt_exp + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero();
    chk("d_wr0", bus_d.wr, 32'd0);
    chk("d_size0", bus_d.size, 32'd0);
    chk("d_addr0", bus_d.addr, 32'd0);
    chk("d_wdata0", bus_d.wdata, 32'd0);
    chk("i_addr0", bus_i.addr, 32'd0);
    chk("i_wdata0", bus_i.wdata, 32'd0);
  endtask

  // One access. a = extra cycles before addr_ok, d = cycles from addr_ok to data_ok,
  // ls = DONE cycles held by longest_stall. mode: 0 normal, 1 flush in first REQ cycle,
  // 2 flush in first WAIT cycle, 3 flush with data_ok, 4 flush in DONE.
  task automatic txn(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                     input int na, input int nd, input int ls, input int mode, input logic [31:0] rv);
    int d;
    d = (mode == 2 && nd < 2) ? 2 : nd;
    set_exp(wen, a, wd);
    sram_en = 1'b1; sram_wen = wen; sram_addr = a; sram_wdata = wd;
    flush = 1'b0; longest_stall = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    cycle_chk(1'b1, 1'b0, 1'b0);
    for (int i = 0; i <= na; i++) begin
      addr_ok = (i == na);
      flush   = (mode == 1 && i == 0);
      cycle_chk(1'b1, 1'b1, 1'b0);
    end
    addr_ok = 1'b0;
    for (int j = 1; j <= d; j++) begin
      data_ok = (j == d);
      rdata   = (j == d) ? rv : $urandom;
      flush   = (mode == 2 && j == 1) || (mode == 3 && j == d);
      cycle_chk(1'b1, 1'b0, 1'b0);
    end
    data_ok = 1'b0; flush = 1'b0; rdata = $urandom;
    if (mode == 0 || mode == 4) begin
      if (wen == 4'b0000) dbuf = rv;
      ibuf = rv;
      if (mode == 4) begin
        longest_stall = 1'b1; flush = 1'b1;
        cycle_chk(1'b0, 1'b0, 1'b1);
      end else begin
        for (int k = 0; k <= ls; k++) begin
          longest_stall = (k < ls);
          cycle_chk(1'b0, 1'b0, 1'b1);
        end
      end
      longest_stall = 1'b0; flush = 1'b0;
    end
  endtask

  task automatic gap(input int g, input logic flush_try);
    sram_en = 1'b0;
    for (int i = 0; i < g; i++) cycle_chk(1'b0, 1'b0, 1'b0);
    if (flush_try) begin
      // Access coinciding with flush: stalls that cycle but must not issue.
      sram_en = 1'b1; flush = 1'b1; sram_wen = 4'($urandom); sram_addr = $urandom;
      cycle_chk(1'b1, 1'b0, 1'b0);
      flush = 1'b0; sram_en = 1'b0;
      cycle_chk(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero();
    cycle_chk(1'b0, 1'b0, 1'b1);

    // Basic read: addr_ok cycle 2, data_ok cycle 4.
    txn(4'b0000, 32'h0000_0100, 32'h0, 1, 2, 0, 0, 32'hDEAD_BEEF);
    chk("cnt_after_read", cnt_d, 32'd5);
    // Write encodings.
    txn(4'b0100, 32'h0000_1003, 32'h1111_2222, 0, 1, 0, 0, 32'h5A5A_5A5A);
    txn(4'b1100, 32'h0000_1003, 32'h3333_4444, 1, 1, 0, 0, 32'h6B6B_6B6B);
    txn(4'b1111, 32'h0000_1003, 32'h5555_6666, 0, 2, 0, 0, 32'h7C7C_7C7C);
    // Result held across a global stall.
    txn(4'b0000, 32'h0000_2002, 32'h0, 0, 1, 3, 0, 32'h1234_5678);
    // Flush in WAIT, then immediate retry from IDLE.
    txn(4'b0000, 32'h0000_3000, 32'h0, 0, 3, 0, 2, 32'hAAAA_5555);
    txn(4'b0000, 32'h0000_3004, 32'h0, 0, 1, 0, 0, 32'h0BAD_F00D);
    // Flush while addr_ok withheld.
    txn(4'b0000, 32'h0000_4000, 32'h0, 3, 2, 0, 1, 32'hCAFE_0001);
    txn(4'b0011, 32'h0000_4001, 32'h0000_BEEF, 1, 2, 0, 3, 32'hCAFE_0002);
    txn(4'b0000, 32'h0000_4008, 32'h0, 0, 1, 0, 4, 32'hCAFE_0003);
    gap(1, 1'b1);

    // Reset while waiting for a response; the late data_ok must be ignored.
    set_exp(4'b1111, 32'h0000_5003, 32'h9999_8888);
    sram_en = 1'b1; sram_wen = 4'b1111; sram_addr = 32'h0000_5003; sram_wdata = 32'h9999_8888;
    cycle_chk(1'b1, 1'b0, 1'b0);
    addr_ok = 1'b1;
    cycle_chk(1'b1, 1'b1, 1'b0);
    addr_ok = 1'b0;
    cycle_chk(1'b1, 1'b0, 1'b0);
    rst = 1'b1; sram_en = 1'b0;
    cycle_chk(1'b0, 1'b0, 1'b0);
    rst = 1'b0; cnt_exp = 32'd0; dbuf = 32'd0; ibuf = 32'd0;
    data_ok = 1'b1; rdata = 32'hFEED_FACE;
    chk_zero();
    cycle_chk(1'b0, 1'b0, 1'b1);
    data_ok = 1'b0;
    chk_zero();
    cycle_chk(1'b0, 1'b0, 1'b1);

    // Randomized accesses.
    for (int n = 0; n < 200; n++) begin
      int k, r, md;
      logic [3:0] w;
      k  = $urandom_range(0, 10);
      w  = (k == 10) ? 4'($urandom) : wen_tab[k];
      r  = $urandom_range(0, 9);
      md = (r < 6) ? 0 : r - 5;
      txn(w, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 4),
          ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3), md, $urandom);
      gap($urandom_range(0, 2), ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_like_port_bridge.md
Name: sram_like_port_bridge

Overview:
- Parametrised converter from the core's single-cycle SRAM-style fetch/memory port to the sram-like request/response interface.
- One instance serves the instruction channel (`WRITE_EN=0`); one serves the data channel (`WRITE_EN=1`). The sram-like side feeds the AXI interface converter.
- Successor to the fixed inst/data converters. Adds:
  - write size/address derivation from byte enables;
  - flush with in-flight response draining;
  - result holding across pipeline-wide stalls;
  - a stall-cycle counter.

Parameters:
- `ADDR_W`, 32, address width; the data path is fixed at 32 bits.
- `WRITE_EN`, 1, 1 = data channel (writes allowed); 0 = instruction channel (`wr` tied 0, `sram_wen` ignored).
- `ALIGN_READ`, 1, 1 = reads issued as word size with `addr[1:0]` forced to 0.
- `CNT_W`, 32, width of the stall-cycle counter.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `sram_en`  in  1  core access request; held until `stall` drops
- `sram_wen`  in  4  byte write enables; 0 = read
- `sram_addr`  in  `ADDR_W`  byte address
- `sram_wdata`  in  32  write data
- `sram_rdata`  out  32  read result, valid when `sram_en && !stall`
- `stall`  out  1  core must hold this port's stage
- `longest_stall`  in  1  global pipeline stall (OR of all stall sources)
- `flush`  in  1  cancel the current access (exception/redirect)
- `req`  out  1  sram-like request
- `wr`  out  1  1 = write
- `size`  out  2  0 = byte, 1 = half, 2 = word
- `addr`  out  `ADDR_W`  request address
- `wdata`  out  32  write data
- `addr_ok`  in  1  request accepted
- `data_ok`  in  1  response valid; arrives at least 1 cycle after its `addr_ok`
- `rdata`  in  32  response data
- `stall_cycles`  out  `CNT_W`  count of cycles with `stall=1`

Behaviour:
- States: IDLE, REQ, WAIT, DONE, DRAIN. On reset: IDLE. Reset mid-transaction abandons it; a later `data_ok` is ignored in IDLE.
- Reset values: `req`=0, `wr`=0, `size`=0, `addr`=0, `wdata`=0, result buffer=0, `stall_cycles`=0. `stall`=0 whenever `sram_en`=0.
- IDLE:
  - On `sram_en && !flush`, latch `wr`/`size`/`addr`/`wdata` and go to REQ. `stall`=1 in that same cycle (combinational).
  - A `sram_en` coinciding with `flush` is ignored.
- REQ:
  - `req`=1 with latched fields stable; `req` is never dropped before `addr_ok`.
  - On `addr_ok`: go to WAIT, or to DRAIN if a flush was recorded in REQ (sticky cancel bit).
- WAIT:
  - On `data_ok`: load the buffer from `rdata` (reads only) and go to DONE.
  - On `flush` without `data_ok`: go to DRAIN.
  - `flush` together with `data_ok`: discard the response and go to IDLE.
- DONE:
  - `stall`=0; `sram_rdata` = buffer.
  - Stay while `longest_stall`=1, so the result is held for the stalled pipeline.
  - Go to IDLE when `longest_stall`=0 or `flush`=1.
  - Back-to-back accesses: the next request is issued from IDLE the following cycle.
- DRAIN:
  - `stall` = `sram_en`; no new request is issued.
  - On `data_ok`: discard and go to IDLE.
- `stall` = `sram_en && state!=DONE`.
- `stall_cycles` increments by 1 per cycle with `stall`=1 and wraps at 2^`CNT_W`.
- Write encoding (`WRITE_EN=1`, `sram_wen`!=0), with `wr`=1:
  - `0001`/`0010`/`0100`/`1000` → `size`=0, `addr[1:0]` = 0/1/2/3.
  - `0011` → `size`=1, `addr[1:0]`=0.
  - `1100` → `size`=1, `addr[1:0]`=2.
  - `1111` → `size`=2, `addr[1:0]`=0.
  - Any other pattern → `size`=2, `addr[1:0]`=0.
  - `wdata` = `sram_wdata` unchanged.
- Reads: `wr`=0, `size`=2. `addr[1:0]` = 0 when `ALIGN_READ`=1, else `sram_addr[1:0]`.
- Write completions also pass through DONE; the buffer is unchanged.

Test Plan:
- Read, `addr_ok` on cycle 2, `data_ok` on cycle 4, `rdata`=0xDEADBEEF, `longest_stall`=0 → `req` high cycles 1–2, `stall` high cycles 0–4, `sram_rdata`=0xDEADBEEF with `stall`=0 on cycle 5, `stall_cycles`=5.
- Writes with `sram_wen`=0100, `addr`=0x1003 → `wr`=1, `size`=0, `addr`=0x1002. Then `sram_wen`=1100 → `size`=1, `addr`=0x1002. Then `sram_wen`=1111 → `size`=2, `addr`=0x1000.
- Read complete, `longest_stall` held for 3 cycles, `rdata` changed to 0x0 → `sram_rdata` stays 0x12345678, no new `req` until `longest_stall` falls.
- `flush` in WAIT, `data_ok` 2 cycles later with 0xAAAA5555, `sram_en`=1 throughout → `stall`=1 through the drain, response discarded, new `req` issued the cycle after IDLE.
- `flush` asserted during REQ while `addr_ok`=0 for 3 cycles → `req` stays 1 until `addr_ok`, then DRAIN, then IDLE; no result delivered.
- `WRITE_EN`=0, `sram_wen`=1111 → `wr`=0, `size`=2; reset asserted in WAIT → all outputs return to 0 and a late `data_ok` is ignored.
